uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Receives 8N1 UART frames from the uart_rxd_i pin and buffers the bytes in an internal FIFO.
//  The consumer reads bytes with a first-word-fall-through read strobe.
//  Its line format, baud timing and FIFO sizing are compatible with the team's uart_tx; the two form a loopback pair.
// PARAMETERS
//  CLK_FREQUENCY_HZ  60000000  system clock frequency
//  BAUD_RATE_HZ      3000000   line rate; CLKS_PER_BIT = CLK_FREQUENCY_HZ/BAUD_RATE_HZ (20 at defaults), must be >= 4
//  FIFO_BITS         4         RX FIFO depth = 2**FIFO_BITS bytes (all entries usable)
// PORTS
//  clk_i         in   1  system clock
//  reset_n_i     in   1  reset, asynchronous, active low
//  uart_rxd_i    in   1  UART RX line, asynchronous to clk_i, idle high
//  rd_stb_i      in   1  pop the head byte; ignored while data_valid_o=0
//  data_o        out  8  head FIFO byte; 8'h00 while data_valid_o=0
//  data_valid_o  out  1  FIFO non-empty
//  led_rx_err_o  out  1  sticky error LED: FIFO overflow or framing error; cleared only by reset
// BEHAVIOUR
//  - Reset (async, reset_n_i=0): state=RX_IDLE, FIFO empty, synchronizer flops=1, data_valid_o=0, data_o=0, led_rx_err_o=0.
//  - uart_rxd_i passes through a 2-flop synchronizer (rxd_s); all decisions use rxd_s only.
//  - clock_count: 16 bits, counts 1..CLKS_PER_BIT; bit_index: 3 bits, LSB first.
//  - RX_IDLE: when rxd_s==0, set clock_count=1 and go to RX_START_BIT.
//  - RX_START_BIT: at clock_count==CLKS_PER_BIT/2 (mid-bit), sample rxd_s.
//      1 -> false start (glitch), return to RX_IDLE.
//      0 -> clock_count=1, bit_index=0, go to RX_DATA_BITS.
//  - RX_DATA_BITS: at clock_count==CLKS_PER_BIT, shift_reg[bit_index]<=rxd_s and restart the count.
//      After bit 7, go to RX_STOP_BIT.
//  - RX_STOP_BIT: at clock_count==CLKS_PER_BIT, sample rxd_s.
//      1 -> push shift_reg into FIFO, go to RX_IDLE.
//      0 -> framing error: drop byte, set led_rx_err_o, go to RX_WAIT_IDLE.
//  - RX_WAIT_IDLE: stay until rxd_s==1 (break/line-low protection), then go to RX_IDLE.
//  - Latency: data_valid_o rises 1 cycle after the stop-bit sample.
//      That is ~2 + 9.5*CLKS_PER_BIT clocks after the start edge on the pin (192 clocks at defaults).
//  - FIFO: rd/wr pointers are FIFO_BITS+1 bits wide.
//      empty = (ptrs equal); full = (index equal, MSB differs).
//  - Push while full (evaluated on pre-cycle state, even if a pop occurs in the same cycle):
//      byte dropped, led_rx_err_o set, FIFO contents unchanged.
//  - Push and pop in the same cycle when not full and not empty: both take effect; the count is unchanged.
//  - Push into an empty FIFO: data_valid_o=1 and data_o=byte on the next cycle.
//  - Pop while empty: ignored, no error.
//  - Pointers wrap modulo 2**(FIFO_BITS+1); the ordering of entries is preserved across wrap.
//  - Reset mid-frame: partial byte discarded, FIFO flushed, receiver resumes at RX_IDLE.
//      A line that is low when reset is released is treated as a start edge.
// STRUCTURE
//  - uart_pkg (shared with uart_tx) holds:
//      rx state enum typedef (RX_IDLE, RX_START_BIT, RX_DATA_BITS, RX_STOP_BIT, RX_WAIT_IDLE; 3 bits);
//      the function clks_per_bit(clk_hz, baud_hz).
//  - Sub-module uart_rx_fifo (parameter FIFO_BITS):
//      ports clk_i, reset_n_i, wr_stb_i, wr_data_i, rd_stb_i, rd_data_o, empty_o, full_o, overflow_o.
//      Memory without reset; pointers with async reset.
//  - Top level holds the synchronizer, the frame FSM and the sticky LED.
// TESTING (defaults: CLKS_PER_BIT=20, FIFO_BITS=4)
//  1. Drive 0xA5 as an 8N1 frame at 20 clks/bit -> data_valid_o=1 and data_o=8'hA5;
//     then one rd_stb_i -> data_valid_o=0, data_o=8'h00.
//  2. Drive a low glitch of 6 clocks on an idle line -> no push, FSM back in RX_IDLE, led_rx_err_o stays 0.
//  3. Send 0x3C with stop bit=0, line held low 60 clocks, then send 0x55 ->
//     0x3C not pushed, led_rx_err_o=1, 0x55 received correctly.
//  4. Send 17 bytes 0x00..0x10 with no pops -> 16 stored, 0x10 dropped, led_rx_err_o=1;
//     16 pops return 0x00..0x0F in order.
//  5. Loop back uart_tx (same params) sending 40 bytes 0x80..0xA7 back-to-back, popping each byte on valid ->
//     all 40 bytes match, pointers wrap, led_rx_err_o=0.
//  6. Assert reset_n_i during data bit 4 of 0xF0 with 3 bytes queued ->
//     immediately data_valid_o=0, data_o=0, led_rx_err_o=0; the next frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-timing helper.
// Used by both uart_rx and uart_tx so that the two sides agree on line timing.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START_BIT = 3'd1,
        RX_DATA_BITS = 3'd2,
        RX_STOP_BIT  = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud_hz);
        return clk_hz / baud_hz;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with first-word-fall-through read port.
// Pointers carry one extra wrap bit so that all 2**FIFO_BITS entries are usable.
module uart_rx_fifo #(
    parameter int FIFO_BITS = 4
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       wr_stb_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_stb_i,
    output logic [7:0] rd_data_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       overflow_o
);
    localparam int DEPTH = 1 << FIFO_BITS;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_BITS:0] wr_ptr;
    logic [FIFO_BITS:0] rd_ptr;
    logic               do_wr;
    logic               do_rd;

    assign empty_o    = (wr_ptr == rd_ptr);
    assign full_o     = (wr_ptr[FIFO_BITS-1:0] == rd_ptr[FIFO_BITS-1:0]) &&
                        (wr_ptr[FIFO_BITS] != rd_ptr[FIFO_BITS]);
    // A write while full is dropped even if a read frees a slot in the same cycle.
    assign do_wr      = wr_stb_i && !full_o;
    assign do_rd      = rd_stb_i && !empty_o;
    assign overflow_o = wr_stb_i && full_o;
    assign rd_data_o  = empty_o ? 8'h00 : mem[rd_ptr[FIFO_BITS-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem[wr_ptr[FIFO_BITS-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchronizer, frame FSM sampling at mid-bit,
// byte FIFO and a sticky error LED for framing errors and FIFO overflow.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ = 60000000,
    parameter int BAUD_RATE_HZ     = 3000000,
    parameter int FIFO_BITS        = 4
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       uart_rxd_i,
    input  logic       rd_stb_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       led_rx_err_o
);
    localparam int          CLKS_PER_BIT = clks_per_bit(CLK_FREQUENCY_HZ, BAUD_RATE_HZ);
    localparam logic [15:0] BIT_END      = 16'(CLKS_PER_BIT);
    localparam logic [15:0] BIT_MID      = 16'(CLKS_PER_BIT / 2);

    logic        rxd_meta;
    logic        rxd_s;
    rx_state_t   state;
    logic [15:0] clock_count;
    logic [2:0]  bit_index;
    logic [7:0]  shift_reg;
    logic        stop_sample;
    logic        push;
    logic        frame_err;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_overflow;

    // Idle-high reset value keeps a quiet line from looking like a start bit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd_i;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= RX_IDLE;
            clock_count <= '0;
            bit_index   <= '0;
            shift_reg   <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (!rxd_s) begin
                        clock_count <= 16'd1;
                        state       <= RX_START_BIT;
                    end
                end
                RX_START_BIT: begin
                    if (clock_count == BIT_MID) begin
                        if (rxd_s) begin
                            state <= RX_IDLE;
                        end else begin
                            clock_count <= 16'd1;
                            bit_index   <= 3'd0;
                            state       <= RX_DATA_BITS;
                        end
                    end else begin
                        clock_count <= clock_count + 16'd1;
                    end
                end
                // From here on every sample lands one full bit after the previous mid-bit point.
                RX_DATA_BITS: begin
                    if (clock_count == BIT_END) begin
                        shift_reg[bit_index] <= rxd_s;
                        clock_count          <= 16'd1;
                        if (bit_index == 3'd7) begin
                            state <= RX_STOP_BIT;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        clock_count <= clock_count + 16'd1;
                    end
                end
                RX_STOP_BIT: begin
                    if (clock_count == BIT_END) begin
                        state <= rxd_s ? RX_IDLE : RX_WAIT_IDLE;
                    end else begin
                        clock_count <= clock_count + 16'd1;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rxd_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign stop_sample = (state == RX_STOP_BIT) && (clock_count == BIT_END);
    assign push        = stop_sample && rxd_s;
    assign frame_err   = stop_sample && !rxd_s;

    uart_rx_fifo #(
        .FIFO_BITS (FIFO_BITS)
    ) u_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .wr_stb_i   (push),
        .wr_data_i  (shift_reg),
        .rd_stb_i   (rd_stb_i),
        .rd_data_o  (data_o),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .overflow_o (fifo_overflow)
    );

    assign data_valid_o = !fifo_empty;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            led_rx_err_o <= 1'b0;
        end else if (frame_err || (fifo_overflow && fifo_full)) begin
            led_rx_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx: frames are generated bit by bit
// and the received bytes are compared against a queue-based FIFO model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB   = 20;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rd_stb = 1'b0;
    logic [7:0] data_o;
    logic       data_valid;
    logic       led_err;

    logic [7:0] q[$];
    bit         errExp = 1'b0;
    bit         autoPop = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         loopCount = 0;

    uart_rx dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .uart_rxd_i   (rxd),
        .rd_stb_i     (rd_stb),
        .data_o       (data_o),
        .data_valid_o (data_valid),
        .led_rx_err_o (led_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock step; in loopback mode every valid head byte is checked and popped.
    task automatic tick();
        @(negedge clk);
        rd_stb = 1'b0;
        if (autoPop && data_valid) begin
            if (q.size() == 0) begin
                checkOutput("spurious valid", 32'(data_valid), 32'd0);
            end else begin
                checkOutput("loop data", 32'(data_o), 32'(q[0]));
                void'(q.pop_front());
                loopCount++;
                rd_stb = 1'b1;
            end
        end
    endtask

    // Drive one 8N1 frame; the model accepts the byte as the stop bit starts.
    task automatic applyStimulus(input logic [7:0] b, input bit stopBit);
        rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) tick();
        end
        rxd = stopBit;
        if (!stopBit) begin
            errExp = 1'b1;
        end else if (q.size() < DEPTH) begin
            q.push_back(b);
        end else begin
            errExp = 1'b1;
        end
        repeat (CPB) tick();
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) tick();
    endtask

    task automatic popAll(input string tag);
        autoPop = 1'b0;
        while (q.size() > 0) begin
            @(negedge clk);
            checkOutput({tag, " valid"}, 32'(data_valid), 32'd1);
            checkOutput({tag, " data"}, 32'(data_o), 32'(q[0]));
            void'(q.pop_front());
            rd_stb = 1'b1;
            @(negedge clk);
            rd_stb = 1'b0;
        end
        @(negedge clk);
        checkOutput({tag, " empty valid"}, 32'(data_valid), 32'd0);
        checkOutput({tag, " empty data"}, 32'(data_o), 32'd0);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        rxd     = 1'b1;
        rd_stb  = 1'b0;
        autoPop = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        errExp = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(negedge clk);
        checkOutput("reset valid", 32'(data_valid), 32'd0);
        checkOutput("reset data", 32'(data_o), 32'd0);
        checkOutput("reset led", 32'(led_err), 32'd0);
        doReset();

        // Single frame, then one pop empties the FIFO.
        applyStimulus(8'hA5, 1'b1);
        idle(5);
        checkOutput("t1 valid", 32'(data_valid), 32'd1);
        checkOutput("t1 data", 32'(data_o), 32'(q[0]));
        popAll("t1");
        checkOutput("t1 led", 32'(led_err), 32'(errExp));

        // Short low glitch is rejected as a false start.
        rxd = 1'b0;
        repeat (6) tick();
        idle(40);
        checkOutput("t2 valid", 32'(data_valid), 32'd0);
        checkOutput("t2 state", 32'(dut.state), 32'(RX_IDLE));
        checkOutput("t2 led", 32'(led_err), 32'(errExp));

        // Framing error with line held low, then a good frame.
        applyStimulus(8'h3C, 1'b0);
        rxd = 1'b0;
        repeat (40) tick();
        idle(20);
        checkOutput("t3 led", 32'(led_err), 32'(errExp));
        checkOutput("t3 no push", 32'(data_valid), 32'd0);
        applyStimulus(8'h55, 1'b1);
        idle(5);
        popAll("t3");

        // Overflow: 17 frames into a 16-entry FIFO.
        doReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'(i), 1'b1);
        end
        idle(5);
        checkOutput("t4 led", 32'(led_err), 32'(errExp));
        checkOutput("t4 count", 32'(q.size()), 32'(DEPTH));
        popAll("t4");

        // Random bytes with random idle gaps.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'($urandom), 1'b1);
            idle($urandom_range(0, 30));
        end
        idle(5);
        popAll("rand");
        checkOutput("rand led", 32'(led_err), 32'(errExp));

        // Back-to-back stream popped on valid; pointers wrap twice.
        doReset();
        autoPop = 1'b1;
        loopCount = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'(8'h80 + i), 1'b1);
        end
        idle(40);
        autoPop = 1'b0;
        checkOutput("t5 received", 32'(loopCount), 32'd40);
        checkOutput("t5 valid", 32'(data_valid), 32'd0);
        checkOutput("t5 led", 32'(led_err), 32'(errExp));

        // Reset in the middle of a frame with bytes queued and the LED lit.
        doReset();
        applyStimulus(8'hEE, 1'b0);
        idle(30);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b1);
        checkOutput("t6 pre led", 32'(led_err), 32'd1);
        checkOutput("t6 pre valid", 32'(data_valid), 32'd1);
        rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rxd = 8'hF0 >> i;
            repeat (CPB) tick();
        end
        rxd = 1'b1;
        repeat (CPB / 2) tick();
        reset_n = 1'b0;
        #1;
        checkOutput("t6 rst valid", 32'(data_valid), 32'd0);
        checkOutput("t6 rst data", 32'(data_o), 32'd0);
        checkOutput("t6 rst led", 32'(led_err), 32'd0);
        checkOutput("t6 rst state", 32'(dut.state), 32'(RX_IDLE));
        q.delete();
        errExp = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(5);
        applyStimulus(8'h12, 1'b1);
        idle(5);
        popAll("t6");
        checkOutput("t6 led", 32'(led_err), 32'(errExp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
